pio_bus_arbiter: RTL and testbench

- Two-master arbiter sharing one single-cycle PIO register slave (Avalon-style address/chipselect/write_n/writedata, combinational readdata) between the HPS bridge (m0) and the WolfCore CPU (m1).
- Round-robin grant, one access in flight, registered slave drive, registered read return with a readdatavalid strobe.
- Sits between the two masters and any pio_* instance in soc_system.

---
 rtl/pio_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_pio_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_bus_arbiter.sv
// Round-robin arbiter sharing one single-cycle PIO register slave between two Avalon-style masters.
// One access in flight: IDLE arbitrates and registers the slave drive, ACCESS lasts exactly one cycle.
module pio_bus_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 2,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              grant_id,
    output logic              busy,
    output logic              protocol_err
);

    // state  | meaning
    // IDLE   | arbitrate; on a request latch the winner into the slave registers
    // ACCESS | slave driven for one cycle; winner's waitrequest low, read data captured at its end
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                grant_q, grant_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic                s_cs_q, s_cs_d;
    logic                s_wn_q, s_wn_d;
    logic [DATA_W-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;
    logic                rdv0_q, rdv0_d, rdv1_q, rdv1_d;
    logic                perr_q, perr_d;

    logic                req0, req1, win;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_write;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign win       = (req0 & req1) ? prio_q : req1;
    assign win_addr  = win ? m1_address   : m0_address;
    assign win_wdata = win ? m1_writedata : m0_writedata;
    // read+write together is performed as a write
    assign win_write = win ? m1_write     : m0_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            prio_q    <= RESET_PRIO;
            grant_q   <= RESET_PRIO;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_cs_q    <= 1'b0;
            s_wn_q    <= 1'b1;
            rd0_q     <= '0;
            rd1_q     <= '0;
            rdv0_q    <= 1'b0;
            rdv1_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            grant_q   <= grant_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_cs_q    <= s_cs_d;
            s_wn_q    <= s_wn_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
            rdv0_q    <= rdv0_d;
            rdv1_q    <= rdv1_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        grant_d   = grant_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_cs_d    = s_cs_q;
        s_wn_d    = s_wn_q;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        rdv0_d    = 1'b0;
        rdv1_d    = 1'b0;
        perr_d    = perr_q | (m0_read & m0_write) | (m1_read & m1_write);
        case (state_q)
            IDLE: begin
                s_cs_d = 1'b0;
                if (req0 | req1) begin
                    state_d   = ACCESS;
                    grant_d   = win;
                    prio_d    = ~win;
                    s_addr_d  = win_addr;
                    s_wdata_d = win_wdata;
                    s_cs_d    = 1'b1;
                    s_wn_d    = ~win_write;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                s_cs_d  = 1'b0;
                s_wn_d  = 1'b1;
                if (s_wn_q) begin
                    if (grant_q) begin
                        rd1_d  = s_readdata;
                        rdv1_d = 1'b1;
                    end else begin
                        rd0_d  = s_readdata;
                        rdv0_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy             = (state_q == ACCESS);
    assign m0_waitrequest   = ~(busy & ~grant_q);
    assign m1_waitrequest   = ~(busy & grant_q);
    assign m0_readdata      = rd0_q;
    assign m1_readdata      = rd1_q;
    assign m0_readdatavalid = rdv0_q;
    assign m1_readdatavalid = rdv1_q;
    assign s_address        = s_addr_q;
    assign s_chipselect     = s_cs_q;
    assign s_write_n        = s_wn_q;
    assign s_writedata      = s_wdata_q;
    assign grant_id         = grant_q;
    assign protocol_err     = perr_q;

endmodule

// File: tb/tb_pio_bus_arbiter.sv
// Directed bench for pio_bus_arbiter with a one-register slave (reset 0xFF, address 0 only).
module tb_pio_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  m0_address = '0, m1_address = '0;
    logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [1:0]  s_address;
    logic        s_chipselect, s_write_n, grant_id, busy, protocol_err;
    logic [31:0] s_writedata, s_readdata;
    logic [31:0] slave_reg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pio_bus_arbiter #(.DATA_W(32), .ADDR_W(2), .RESET_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .grant_id(grant_id), .busy(busy), .protocol_err(protocol_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            slave_reg <= 32'h0000_00FF;
        else if (s_chipselect && !s_write_n && s_address == 2'd0)
            slave_reg <= s_writedata;
    end
    assign s_readdata = (s_address == 2'd0) ? slave_reg : 32'h0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL reset_wait: got %b%b expected 11", m0_waitrequest, m1_waitrequest);
        end
        checks++;
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin
            errors++; $display("FAIL reset_read: got rdv %b%b rd %h %h expected 00 0 0",
                               m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata);
        end
        checks++;
        if (s_chipselect !== 1'b0 || s_write_n !== 1'b1 || s_address !== 2'd0 || s_writedata !== 32'h0) begin
            errors++; $display("FAIL reset_slave: got cs %b wn %b a %h d %h expected 0 1 0 0",
                               s_chipselect, s_write_n, s_address, s_writedata);
        end
        checks++;
        if (grant_id !== 1'b0 || busy !== 1'b0 || protocol_err !== 1'b0) begin
            errors++; $display("FAIL reset_status: got g %b b %b e %b expected 0 0 0", grant_id, busy, protocol_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        next_cycle();
        m0_address = 2'd0; m0_writedata = 32'h0000_00A5; m0_write = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_req_cycle: got wait %b busy %b expected 1 0", m0_waitrequest, busy);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || busy !== 1'b1 || grant_id !== 1'b0) begin
            errors++; $display("FAIL wr_accept: got w0 %b w1 %b busy %b g %b expected 0 1 1 0",
                               m0_waitrequest, m1_waitrequest, busy, grant_id);
        end
        checks++;
        if (s_chipselect !== 1'b1 || s_write_n !== 1'b0 || s_writedata !== 32'hA5) begin
            errors++; $display("FAIL wr_slave_drive: got cs %b wn %b d %h expected 1 0 a5", s_chipselect, s_write_n, s_writedata);
        end
        next_cycle();
        m0_write = 1'b0;
        @(negedge clk);
        checks++;
        if (slave_reg !== 32'hA5 || m0_waitrequest !== 1'b1 || s_chipselect !== 1'b0) begin
            errors++; $display("FAIL wr_done: got reg %h w0 %b cs %b expected a5 1 0", slave_reg, m0_waitrequest, s_chipselect);
        end
    endtask

    task automatic test_read_m1();
        do_reset();
        m1_address = 2'd0; m1_read = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL rd1_req_cycle: got wait %b expected 1", m1_waitrequest);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b0 || grant_id !== 1'b1 || s_write_n !== 1'b1 || m1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rd1_accept: got w1 %b g %b wn %b rdv %b expected 0 1 1 0",
                               m1_waitrequest, grant_id, s_write_n, m1_readdatavalid);
        end
        next_cycle();
        m1_read = 1'b0;
        @(negedge clk);
        checks++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hFF || m0_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rd1_valid: got rdv1 %b rd %h rdv0 %b expected 1 ff 0",
                               m1_readdatavalid, m1_readdata, m0_readdatavalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'hFF || m0_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rd1_after: got rdv1 %b rd %h rdv0 %b expected 0 ff 0",
                               m1_readdatavalid, m1_readdata, m0_readdatavalid);
        end
    endtask

    task automatic test_alternation();
        logic [31:0] d0, d1, exp_d;
        logic        exp_g;
        do_reset();
        d0 = 32'h100; d1 = 32'h200;
        m0_address = 2'd0; m1_address = 2'd0;
        m0_writedata = d0; m1_writedata = d1;
        m0_write = 1'b1; m1_write = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_g = g[0];
            exp_d = exp_g ? d1 : d0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
                errors++; $display("FAIL alt_idle%0d: got busy %b w %b%b expected 0 11", g, busy, m0_waitrequest, m1_waitrequest);
            end
            next_cycle();
            @(negedge clk);
            checks++;
            if (grant_id !== exp_g || m0_waitrequest !== exp_g || m1_waitrequest !== ~exp_g || s_writedata !== exp_d) begin
                errors++; $display("FAIL alt_grant%0d: got g %b w %b%b d %h expected g %b d %h",
                                   g, grant_id, m0_waitrequest, m1_waitrequest, s_writedata, exp_g, exp_d);
            end
            next_cycle();
            if (exp_g) begin d1 = d1 + 1; m1_writedata = d1; end
            else       begin d0 = d0 + 1; m0_writedata = d0; end
        end
        m0_write = 1'b0; m1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (slave_reg !== 32'h201) begin
            errors++; $display("FAIL alt_final: got %h expected 201", slave_reg);
        end
        next_cycle();
    endtask

    task automatic test_protocol_err();
        m1_address = 2'd0; m1_writedata = 32'h1234; m1_read = 1'b1; m1_write = 1'b1;
        @(negedge clk);
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++; $display("FAIL perr_before: got %b expected 0", protocol_err);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b0 || s_write_n !== 1'b0 || protocol_err !== 1'b1) begin
            errors++; $display("FAIL perr_access: got w1 %b wn %b err %b expected 0 0 1", m1_waitrequest, s_write_n, protocol_err);
        end
        next_cycle();
        m1_read = 1'b0; m1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (slave_reg !== 32'h1234 || m1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL perr_write: got reg %h rdv %b expected 1234 0", slave_reg, m1_readdatavalid);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++; $display("FAIL perr_sticky: got %b expected 1", protocol_err);
        end
    endtask

    task automatic test_read_addr3();
        logic [1:0] addrs [2];
        logic [31:0] exp_rd [2];
        addrs[0] = 2'd0; exp_rd[0] = 32'h1234;
        addrs[1] = 2'd3; exp_rd[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            m0_address = addrs[k]; m0_read = 1'b1;
            next_cycle();
            @(negedge clk);
            checks++;
            if (m0_waitrequest !== 1'b0 || s_address !== addrs[k]) begin
                errors++; $display("FAIL rd0_accept%0d: got w0 %b a %h expected 0 %h", k, m0_waitrequest, s_address, addrs[k]);
            end
            next_cycle();
            m0_read = 1'b0;
            @(negedge clk);
            checks++;
            if (m0_readdatavalid !== 1'b1 || m0_readdata !== exp_rd[k] || m1_readdatavalid !== 1'b0) begin
                errors++; $display("FAIL rd0_valid%0d: got rdv %b rd %h rdv1 %b expected 1 %h 0",
                                   k, m0_readdatavalid, m0_readdata, m1_readdatavalid, exp_rd[k]);
            end
            next_cycle();
            @(negedge clk);
            checks++;
            if (m0_readdatavalid !== 1'b0 || m0_readdata !== exp_rd[k]) begin
                errors++; $display("FAIL rd0_once%0d: got rdv %b rd %h expected 0 %h", k, m0_readdatavalid, m0_readdata, exp_rd[k]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        m0_address = 2'd0; m0_read = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_access: got w0 %b busy %b expected 0 1", m0_waitrequest, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_chipselect !== 1'b0 || busy !== 1'b0 ||
            grant_id !== 1'b0 || protocol_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got w %b%b cs %b busy %b g %b err %b expected 11 0 0 0 0",
                               m0_waitrequest, m1_waitrequest, s_chipselect, busy, grant_id, protocol_err);
        end
        next_cycle();
        m0_read = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_rdv_hold: got %b%b expected 00", m0_readdatavalid, m1_readdatavalid);
        end
        next_cycle();
        reset = 1'b0;
        m1_address = 2'd0; m1_writedata = 32'h55; m1_write = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_readdatavalid !== 1'b0 || m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after: got rdv0 %b w1 %b expected 0 1", m0_readdatavalid, m1_waitrequest);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b0 || grant_id !== 1'b1) begin
            errors++; $display("FAIL rst_mid_next_accept: got w1 %b g %b expected 0 1", m1_waitrequest, grant_id);
        end
        next_cycle();
        m1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (slave_reg !== 32'h55) begin
            errors++; $display("FAIL rst_mid_next_write: got %h expected 55", slave_reg);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_m1();
        test_alternation();
        test_protocol_err();
        test_read_addr3();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
